bus_strobe_seq: RTL
===================

BUS_STROBE_SEQ -- requirements
Module: bus_strobe_seq

Interface
REQ-001 Parameter WAIT_TABLE, default 24'b011_000_000_000_000_000_000_000: packed per-region wait counts; region n uses bits [3n+2:3n].
REQ-002 The block SHALL have one clock; reset SHALL be synchronous and active-high, with ports named clk and rst.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req  in  1  CPU bus-cycle request, sampled on clk only in IDLE.
REQ-006 addr  in  16  CPU address; region = addr[15:13].
REQ-007 we  in  1  1 = write cycle, 0 = read cycle.
REQ-008 dec_a, dec_b, dec_c  out  1 each  decoder select; dec_a = region MSB (addr[15]), dec_c = LSB (addr[13]).
REQ-009 dec_g1  out  1  decoder active-high enable.
REQ-010 dec_g2a_n, dec_g2b_n  out  1 each  decoder active-low enables.
REQ-011 oe_n, we_n  out  1 each  active-low read and write strobes.
REQ-012 ready  out  1  one-cycle completion pulse.
REQ-013 busy  out  1  high while a cycle is in progress.

Function
REQ-014 FSM states SHALL be IDLE, SETUP, STROBE and HOLD.
REQ-015 In IDLE with req=1 at a clk edge, the block SHALL latch addr[15:13] and we and enter SETUP; req in any other state SHALL be ignored and not queued.
REQ-016 SETUP: one cycle; dec_a/b/c SHALL be driven from the latched region; dec_g1=0, dec_g2b_n=0, dec_g2a_n=1 (decoder disabled while select settles).
REQ-017 STROBE: W+1 cycles, W = WAIT_TABLE field of the latched region (0..7); dec_g1=1, dec_g2a_n=0, dec_g2b_n=0; oe_n=0 if read, we_n=0 if write.
REQ-018 HOLD: one cycle; dec_g1=0, dec_g2a_n=1, dec_g2b_n=0, strobes deasserted, select unchanged, ready=1; the next state SHALL be IDLE unconditionally.
REQ-019 Latency: req accepted at edge k gives SETUP in cycle k+1, STROBE in cycles k+2..k+2+W, HOLD/ready in cycle k+3+W and IDLE in cycle k+4+W; the earliest next accept is edge k+4+W.
REQ-020 dec_a/b/c SHALL stay constant from SETUP through HOLD, and SHALL hold their last value in IDLE.
REQ-021 busy SHALL be 1 in SETUP, STROBE and HOLD, and 0 in IDLE.
REQ-022 oe_n and we_n SHALL never be low simultaneously, and neither SHALL be low outside STROBE.
REQ-023 The wait counter SHALL load W on entering STROBE, decrement each STROBE cycle, and leave STROBE when it is 0; it SHALL not wrap.
REQ-024 All outputs SHALL be registered and glitch-free.

Reset
REQ-025 On rst=1 at a clk edge, the state SHALL become IDLE, aborting any cycle in progress without a ready pulse.
REQ-026 Reset values SHALL be: dec_a/b/c=000, dec_g1=0, dec_g2a_n=1, dec_g2b_n=1, oe_n=1, we_n=1, ready=0, busy=0, wait counter=0.
REQ-027 req high during reset SHALL be ignored; the first accept is at the first edge with rst=0.

Configuration
REQ-028 With macro BUS_EXT_WAIT_EN defined, the block SHALL add input ext_wait (1 bit); while ext_wait=1 with the counter at 0, STROBE SHALL extend one cycle per clk, and HOLD SHALL follow the first counter-0 cycle with ext_wait=0.
REQ-029 Without BUS_EXT_WAIT_EN, the ext_wait port SHALL be absent and STROBE length SHALL be exactly W+1.

Structure
REQ-030 Package bus_seq_pkg SHALL hold the FSM state enum, REGION_W=3, WAIT_W=3 and the default wait-table constant.
REQ-031 The wait counter SHALL be a sub-module named bus_wait_cnt (load, decrement, zero flag); the FSM and output registers SHALL stay in bus_strobe_seq.

Verification
REQ-032 Reset: after rst pulse -> all outputs at REQ-026 values; req held high during rst -> busy stays 0.
REQ-033 Read, addr=16'h2000 (region 1, W=0), req at edge k -> dec_a/b/c=001 from cycle k+1; g1=1, oe_n=0 only in cycle k+2; ready=1 only in cycle k+3; busy=0 in cycle k+4.
REQ-034 Write, addr=16'hE000 (region 7, W=3) -> dec_a/b/c=111; we_n=0 for 4 cycles (k+2..k+5); oe_n stays 1; ready in cycle k+6.
REQ-035 req held high continuously, region 0 -> accepts at edges k, k+4, k+8; no overlapping strobes; exactly one ready per accept.
REQ-036 rst asserted mid-STROBE, region 7 -> next cycle IDLE with REQ-026 values; no ready pulse.
REQ-037 BUS_EXT_WAIT_EN, region 1, ext_wait=1 for 2 cycles from STROBE start -> STROBE lasts 3 cycles; ready in cycle k+5.

Source files
------------

// File: rtl/bus_seq_pkg.sv
// Shared types and constants for the bus strobe sequencer: FSM states, field widths,
// the default per-region wait table and the registered output bundle.
package bus_seq_pkg;

   localparam int REGION_W = 3;
   localparam int WAIT_W   = 3;
   localparam int TABLE_W  = (1 << REGION_W) * WAIT_W;

   localparam logic [TABLE_W-1:0] DEFAULT_WAIT_TABLE = 24'b011_000_000_000_000_000_000_000;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD
   } state_e;

   typedef struct packed {
      logic [REGION_W-1:0] dec;
      logic                g1;
      logic                g2a_n;
      logic                g2b_n;
      logic                oe_n;
      logic                we_n;
      logic                ready;
      logic                busy;
   } bus_out_t;

   localparam bus_out_t OUT_RESET = '{
      dec:   '0,
      g1:    1'b0,
      g2a_n: 1'b1,
      g2b_n: 1'b1,
      oe_n:  1'b1,
      we_n:  1'b1,
      ready: 1'b0,
      busy:  1'b0
   };

   function automatic logic [WAIT_W-1:0] wait_of(input logic [TABLE_W-1:0]  tbl,
                                                 input logic [REGION_W-1:0] region);
      return tbl[region*WAIT_W +: WAIT_W];
   endfunction

endpackage

// File: rtl/bus_wait_cnt.sv
// Strobe wait counter: loads the region wait count, counts down to zero and
// saturates there, exposing only a zero flag to the sequencer.
module bus_wait_cnt
   import bus_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              dec,
   input  logic [WAIT_W-1:0] load_val,
   output logic              zero
);

   logic [WAIT_W-1:0] cnt_q;
   logic [WAIT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - WAIT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/bus_strobe_seq.sv
// Address-decoder / strobe sequencer for a CPU bus cycle: IDLE -> SETUP -> STROBE (W+1) -> HOLD.
// Optional macro BUS_EXT_WAIT_EN adds the ext_wait input that stretches STROBE.
module bus_strobe_seq
   import bus_seq_pkg::*;
#(
   parameter logic [TABLE_W-1:0] WAIT_TABLE = DEFAULT_WAIT_TABLE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic [15:0] addr,
   input  logic        we,
`ifdef BUS_EXT_WAIT_EN
   input  logic        ext_wait,
`endif
   output logic        dec_a,
   output logic        dec_b,
   output logic        dec_c,
   output logic        dec_g1,
   output logic        dec_g2a_n,
   output logic        dec_g2b_n,
   output logic        oe_n,
   output logic        we_n,
   output logic        ready,
   output logic        busy
);

   state_e              state_q, state_d;
   logic [REGION_W-1:0] region_q, region_d;
   logic                we_q, we_d;
   bus_out_t            out_q, out_d;
   logic                cnt_zero;
   logic                ext_hold;
   logic                unused_addr;

   assign unused_addr = ^addr[12:0];

`ifdef BUS_EXT_WAIT_EN
   assign ext_hold = ext_wait;
`else
   assign ext_hold = 1'b0;
`endif

   bus_wait_cnt u_wait_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (state_q == SETUP),
      .dec      (state_q == STROBE),
      .load_val (wait_of(WAIT_TABLE, region_q)),
      .zero     (cnt_zero)
   );

   // NOTE: registers update only with <= so every flop samples the pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         region_q <= '0;
         we_q     <= 1'b0;
         out_q    <= OUT_RESET;
      end else begin
         state_q  <= state_d;
         region_q <= region_d;
         we_q     <= we_d;
         out_q    <= out_d;
      end
   end

   // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d  = state_q;
      region_d = region_q;
      we_d     = we_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               state_d  = SETUP;
               region_d = addr[15:13];
               we_d     = we;
            end
         end
         SETUP:   state_d = STROBE;
         STROBE:  if (cnt_zero && !ext_hold) state_d = HOLD;
         HOLD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so each pin is a clean flop.
   always_comb begin
      out_d       = out_q;
      out_d.g1    = 1'b0;
      out_d.g2a_n = 1'b1;
      out_d.g2b_n = 1'b1;
      out_d.oe_n  = 1'b1;
      out_d.we_n  = 1'b1;
      out_d.ready = 1'b0;
      out_d.busy  = 1'b0;
      case (state_d)
         SETUP: begin
            out_d.dec   = region_d;
            out_d.g2b_n = 1'b0;
            out_d.busy  = 1'b1;
         end
         STROBE: begin
            out_d.dec   = region_d;
            out_d.g1    = 1'b1;
            out_d.g2a_n = 1'b0;
            out_d.g2b_n = 1'b0;
            out_d.oe_n  = we_d;
            out_d.we_n  = !we_d;
            out_d.busy  = 1'b1;
         end
         HOLD: begin
            out_d.dec   = region_d;
            out_d.g2b_n = 1'b0;
            out_d.ready = 1'b1;
            out_d.busy  = 1'b1;
         end
         default: ;
      endcase
   end

   assign dec_a     = out_q.dec[2];
   assign dec_b     = out_q.dec[1];
   assign dec_c     = out_q.dec[0];
   assign dec_g1    = out_q.g1;
   assign dec_g2a_n = out_q.g2a_n;
   assign dec_g2b_n = out_q.g2b_n;
   assign oe_n      = out_q.oe_n;
   assign we_n      = out_q.we_n;
   assign ready     = out_q.ready;
   assign busy      = out_q.busy;

endmodule
